// File: rtl/mem_slot_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_slot_arbiter
// Brief    : Generates the 6502 phase clock (phi) and time-shares one memory
//            port between the video scanner (phi low) and the CPU (phi high).
//            A half period is stretched while its access still waits for ack.
// Options  : STALL_COUNT_EN - when defined, stall_cnt counts stretched clks;
//            otherwise stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_slot_arbiter #(
  parameter int DIV    = 25,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              phi,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       stall_cnt
);

  localparam int CNT_W = $clog2(2 * DIV);

  // Last count of the video half, first count of the CPU half, last count.
  localparam logic [CNT_W-1:0] C_VID_END = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] C_HALF    = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] C_CPU_END = CNT_W'(2 * DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VID_WAIT = 3'd1,
    ST_VID_DONE = 3'd2,
    ST_CPU_WAIT = 3'd3,
    ST_CPU_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                phi_q, phi_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0]   cpu_din_q, cpu_din_d;
  logic [DATA_W-1:0]   vid_data_q, vid_data_d;
  logic                vid_valid_q, vid_valid_d;

  logic                w_ack;
  logic                w_hold;

  // An ack only counts while a request is actually outstanding.
  assign w_ack = mem_ack & mem_req_q;

  // Phase counter: freeze at the end of a half whose access is still open.
  always_comb begin
    w_hold = 1'b0;
    if (!w_ack) begin
      if ((state_q == ST_VID_WAIT) && (cnt_q == C_VID_END)) w_hold = 1'b1;
      if ((state_q == ST_CPU_WAIT) && (cnt_q == C_CPU_END)) w_hold = 1'b1;
    end
    if (w_hold)                  cnt_d = cnt_q;
    else if (cnt_q == C_CPU_END) cnt_d = '0;
    else                         cnt_d = cnt_q + CNT_W'(1);
    // phi tracks the count it will hold after this edge.
    phi_d = (cnt_d >= C_HALF);
  end

  // Slot state machine: next state and next register values.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rd_d    = cpu_rd_q;
    cpu_din_d   = cpu_din_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_CPU_DONE: begin
        if (cnt_q == '0) begin
          mem_addr_d = vid_addr;
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
          state_d    = ST_VID_WAIT;
        end
      end
      ST_VID_WAIT: begin
        if (w_ack) begin
          vid_data_d  = mem_rdata;
          vid_valid_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = ST_VID_DONE;
        end
      end
      ST_VID_DONE: begin
        if (cnt_q == C_HALF) begin
          mem_addr_d  = cpu_addr;
          mem_we_d    = ~cpu_rw;
          mem_wdata_d = cpu_dout;
          cpu_rd_d    = cpu_rw;
          mem_req_d   = 1'b1;
          state_d     = ST_CPU_WAIT;
        end
      end
      ST_CPU_WAIT: begin
        if (w_ack) begin
          if (cpu_rd_q) cpu_din_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_CPU_DONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, phase and memory-side registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      phi_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rd_q    <= 1'b0;
      cpu_din_q   <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phi_q       <= phi_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_din_q   <= cpu_din_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
    end
  end

`ifdef STALL_COUNT_EN
  logic [15:0] stall_q;

  // Count every clk the phase counter is frozen, saturating at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (w_hold && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign phi       = phi_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_din   = cpu_din_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_slot_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_slot_arbiter
// Brief    : Self-checking bench for mem_slot_arbiter (DIV = 4). A memory
//            responder with chosen ack delays feeds a slot-level model: each
//            phi half lasts DIV clks or until the clk after its ack, whichever
//            is later; requests issue one clk after every phi edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_slot_arbiter;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        phi;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [15:0] stall_cnt;

  mem_slot_arbiter #(.DIV(DIV), .ADDR_W(16), .DATA_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .phi       (phi),
    .cpu_addr  (cpu_addr),
    .cpu_rw    (cpu_rw),
    .cpu_dout  (cpu_dout),
    .cpu_din   (cpu_din),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slot model state
  int          n;
  int          t_r, t_a, last_trans;
  bit          pending, has_txn, cur_vid, cur_we, model_phi, exp_vv;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata, ack_data, exp_vid, exp_din;
  int unsigned exp_stall;
  int          fixed_d, force_vid_d, force_cpu_d;
  bit          stray_en, rand_en;
  logic [7:0]  mem [0:65535];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic pick_delay(input bit is_vid, output int d);
    if (is_vid && force_vid_d > 0) begin
      d = force_vid_d;
      force_vid_d = 0;
    end else if (!is_vid && force_cpu_d > 0) begin
      d = force_cpu_d;
      force_cpu_d = 0;
    end else if (fixed_d > 0) begin
      d = fixed_d;
    end else if ($urandom_range(0, 1) == 0) begin
      d = $urandom_range(1, 3);
    end else begin
      d = $urandom_range(1, 12);
    end
  endtask

  task automatic model_init();
    n = 0; t_r = 0; t_a = 0; last_trans = 0;
    pending = 0; has_txn = 0; cur_vid = 0; cur_we = 0; model_phi = 0; exp_vv = 0;
    exp_vid = 8'h00; exp_din = 8'h00; exp_stall = 0;
  endtask

  // Called at each negedge after posedge number n.
  task automatic observe();
    int d;
    int edge_t;
    exp_vv = 1'b0;
    if (!pending && n == last_trans + 1) begin
      pending   = 1'b1;
      has_txn   = 1'b1;
      cur_vid   = !model_phi;
      cur_addr  = cur_vid ? vid_addr : cpu_addr;
      cur_we    = cur_vid ? 1'b0 : !cpu_rw;
      cur_wdata = cpu_dout;
      pick_delay(cur_vid, d);
      t_r = n;
      t_a = n + d;
    end else if (pending && n == t_a) begin
      pending = 1'b0;
      if (cur_vid) begin
        exp_vid = ack_data;
        exp_vv  = 1'b1;
      end else if (cur_we) begin
        mem[cur_addr] = cur_wdata;
      end else begin
        exp_din = ack_data;
      end
    end else if (pending && n >= t_r + DIV - 1) begin
      if (exp_stall != 32'hFFFF) exp_stall++;
    end
    edge_t = (t_r + DIV - 1 > t_a) ? (t_r + DIV - 1) : t_a;
    if (has_txn && n == edge_t) begin
      model_phi  = !model_phi;
      last_trans = n;
      has_txn    = 1'b0;
    end

    chk("phi", 32'(phi), 32'(model_phi));
    chk("mem_req", 32'(mem_req), 32'(pending));
    if (pending) begin
      chk("mem_addr", 32'(mem_addr), 32'(cur_addr));
      chk("mem_we", 32'(mem_we), 32'(cur_we));
      if (cur_we) chk("mem_wdata", 32'(mem_wdata), 32'(cur_wdata));
    end
    chk("vid_valid", 32'(vid_valid), 32'(exp_vv));
    chk("vid_data", 32'(vid_data), 32'(exp_vid));
    chk("cpu_din", 32'(cpu_din), 32'(exp_din));
`ifdef STALL_COUNT_EN
    chk("stall_cnt", 32'(stall_cnt), exp_stall);
`else
    chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Memory responder for the next edge
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    if (pending && n + 1 == t_a) begin
      mem_ack   = 1'b1;
      mem_rdata = cur_we ? 8'($urandom) : mem[cur_addr];
      ack_data  = mem_rdata;
    end else if (!pending && stray_en && $urandom_range(0, 5) == 0) begin
      mem_ack = 1'b1;
    end

    if (rand_en && $urandom_range(0, 2) == 0) begin
      cpu_addr = 16'h3A00 | 16'($urandom_range(0, 15));
      cpu_rw   = 1'($urandom_range(0, 1));
      cpu_dout = 8'($urandom);
      vid_addr = 16'h3A00 | 16'($urandom_range(0, 15));
    end
  endtask

  task automatic run(input int num);
    for (int k = 0; k < num; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      observe();
    end
  endtask

  // Release reset at the current negedge and check the reset state.
  task automatic release_reset();
    reset = 1'b0;
    model_init();
    chk("rst_phi", 32'(phi), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu_din", 32'(cpu_din), 32'd0);
    chk("rst_vid_data", 32'(vid_data), 32'd0);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    reset = 1'b1;
    cpu_addr = 16'h1111; cpu_rw = 1'b1; cpu_dout = 8'h00;
    vid_addr = 16'h1234; mem_rdata = 8'h00; mem_ack = 1'b0;
    ack_data = 8'h00; cur_addr = 16'h0; cur_wdata = 8'h0;
    fixed_d = 1; force_vid_d = 0; force_cpu_d = 0; stray_en = 0; rand_en = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8) ^ 8'h5A);
    model_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    release_reset();

    // Ack one clk after every request: plain 8-clk phi period.
    run(24);

    // CPU read of FFFC.
    mem[16'hFFFC] = 8'h62;
    cpu_addr = 16'hFFFC; cpu_rw = 1'b1;
    run(16);
    chk("t2_cpu_din", 32'(cpu_din), 32'h62);

    // CPU write leaves cpu_din alone.
    cpu_addr = 16'h0400; cpu_rw = 1'b0; cpu_dout = 8'hA5;
    run(16);
    chk("t3_cpu_din", 32'(cpu_din), 32'h62);

    // Video ack 10 clks late: 7 stretched clks with DIV = 4.
    cpu_rw = 1'b1;
    force_vid_d = 10;
    run(32);
`ifdef STALL_COUNT_EN
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd7);
`else
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Video fetch of 2000.
    mem[16'h2000] = 8'h7F;
    vid_addr = 16'h2000;
    run(16);
    chk("t6_vid_data", 32'(vid_data), 32'h7F);

    // Random delays, stray acks and changing inputs.
    fixed_d = 0; stray_en = 1; rand_en = 1;
    run(600);

    // Reset in the middle of a CPU access.
    stray_en = 0;
    force_cpu_d = 6;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      run(1);
      if (pending && !cur_vid && n > t_r) found = 1;
    end
    chk("t5_reach_cpu_wait", 32'(found), 32'd1);
    mem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_req_async", 32'(mem_req), 32'd0);
    chk("t5_phi_async", 32'(phi), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_req_held", 32'(mem_req), 32'd0);
    chk("t5_cpu_din_held", 32'(cpu_din), 32'd0);
    // Late ack stays high across the first edge after release.
    release_reset();
    stray_en = 1;
    run(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
